// File: rtl/r_forward_arbiter_pkg.sv
// Shared constants for the read-forward merge path.
// Beat layout and a width helper used by the arbiter.
package r_forward_arbiter_pkg;

    localparam int DATA_W   = 77;
    localparam int ADDR_LSB = 33;
    localparam int ADDR_MSB = 68;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_skid2.sv
// Two-entry valid/ready buffer: head drives the outputs,
// skid holds the second beat. Load enable depends on count only.
module axi_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_en,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    input  logic             drain_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] skid;
    logic             load;
    logic             drain;

    assign load_en    = (count != 2'd2);
    assign head_valid = (count != 2'd0);
    assign load       = load_valid & load_en;
    assign drain      = head_valid & drain_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            skid  <= '0;
        end else begin
            unique case ({load, drain})
                2'b10: begin
                    if (count == 2'd0) head <= load_data;
                    else               skid <= load_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= skid;
                    count <= count - 2'd1;
                end
                // only reachable with count==1: new beat replaces head
                2'b11: head <= load_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/r_forward_arbiter.sv
// Round-robin merge of per-master read-forward streams onto one port,
// tagging each beat with its source index for response routing.
module r_forward_arbiter
    import r_forward_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int SRC_W     = clog2(NUM_PORTS)
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic [NUM_PORTS*DATA_W-1:0] DATAi,
    input  logic [NUM_PORTS-1:0]        VALIDi,
    output logic [NUM_PORTS-1:0]        READYi,
    output logic [DATA_W-1:0]           DATAo,
    output logic [SRC_W-1:0]            SRCo,
    output logic                        VALIDo,
    input  logic                        READYo
);

    logic [NUM_PORTS-1:0]    grant;
    logic [SRC_W-1:0]        gnt_idx;
    logic [SRC_W-1:0]        rr_ptr;
    logic [SRC_W-1:0]        next_ptr;
    logic                    found;
    logic                    load_en;
    logic                    accept;
    logic [DATA_W-1:0]       sel_data;
    logic [SRC_W+DATA_W-1:0] buf_head;
    logic [1:0]              buf_count;

    // first valid port at or after the pointer, wrapping to 0
    always_comb begin
        int p;
        p       = 0;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            p = int'(rr_ptr) + i;
            if (p >= NUM_PORTS) p = p - NUM_PORTS;
            if (!found && VALIDi[p]) begin
                found    = 1'b1;
                grant[p] = 1'b1;
                gnt_idx  = SRC_W'(p);
            end
        end
    end

    always_comb begin
        if (int'(gnt_idx) == NUM_PORTS - 1) next_ptr = '0;
        else                               next_ptr = gnt_idx + 1'b1;
    end

    assign sel_data = DATAi[int'(gnt_idx)*DATA_W +: DATA_W];
    assign READYi   = grant & {NUM_PORTS{load_en & ARESETn}};
    assign accept   = found & load_en;

    always_ff @(posedge ACLK) begin
        if (!ARESETn)    rr_ptr <= '0;
        else if (accept) rr_ptr <= next_ptr;
    end

    axi_skid2 #(
        .WIDTH (SRC_W + DATA_W)
    ) u_buf (
        .clk         (ACLK),
        .rst_n       (ARESETn),
        .load_data   ({gnt_idx, sel_data}),
        .load_valid  (found),
        .load_en     (load_en),
        .head        (buf_head),
        .head_valid  (VALIDo),
        .drain_ready (READYo),
        .count       (buf_count)
    );

    assign {SRCo, DATAo} = buf_head;

endmodule
